ram_param: RTL and testbench



---
 rtl/ram_param_pkg.sv | 19 +
 rtl/ram_param_if.sv | 25 ++
 rtl/ram_param_clear_seq.sv | 62 ++++++
 rtl/ram_param.sv | 91 +++++++++
 tb/tb_ram_param.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_param_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ram_pkg
//  Description : Shared types and default sizes for the parameterised RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

  // Sweep controller states: zeroing the array, then normal access.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

  localparam int RAM_WIDTH = 16;
  localparam int RAM_DEPTH = 8;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_param_if.sv
`default_nettype none
// ============================================================================
//  Interface   : ram_param_if
//  Description : Access bus of the parameterised RAM (write data, address,
//                write enable, registered read data, clear-busy flag).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] in;
  logic [AW-1:0]    addr;
  logic             load;
  logic [WIDTH-1:0] out;
  logic             busy;

  // Requester side drives the access, RAM side returns data and status.
  modport master (output in, output addr, output load, input out, input busy);
  modport slave  (input in, input addr, input load, output out, output busy);

endinterface : ram_param_if
`default_nettype wire

// File: rtl/ram_param_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ram_clear_seq
//  Description : Post-reset clear sequencer. Walks a pointer over every word
//                of the array, requesting a zero write each cycle, then
//                parks in READY until the next reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH
) (
  input  wire                      clk,
  input  wire                      rst_n,
  output logic                     busy_o,
  output logic                     clr_we_o,
  output logic [$clog2(DEPTH)-1:0] clr_addr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  ram_state_t    state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;

  // Sweep FSM: one word per cycle; the last write also releases busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          // Pointer is exactly AW bits, so it wraps back to 0 on exit.
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == LAST_ADDR) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          state_q <= READY;
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Zero writes are requested exactly while the sweep is running.
  assign busy_o     = busy_q;
  assign clr_we_o   = busy_q;
  assign clr_addr_o = ptr_q;

endmodule : ram_clear_seq
`default_nettype wire

// File: rtl/ram_param.sv
`default_nettype none
// ============================================================================
//  Module      : ram_param
//  Description : Single-port RAM, WIDTH x DEPTH (DEPTH a power of two, >= 2),
//                registered read data, hardware zero-sweep after reset.
//                Optional macro RAM_PARAM_WRITE_THROUGH_EN selects write-first
//                read data; default build is read-first.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_param
  import ram_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH,
  parameter int DEPTH = RAM_DEPTH
) (
  input  wire          clk,
  input  wire          rst_n,
  ram_param_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  logic             busy;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  ram_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // Write-port source: sweep owns the port while busy, user afterwards.
  always_comb begin
    we    = bus.load;
    waddr = bus.addr;
    wdata = bus.in;
    if (busy) begin
      we    = clr_we;
      waddr = clr_addr;
      wdata = '0;
    end
  end

  // Storage array; deliberately not reset, the sweep takes care of it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Next read data: forced to zero during the sweep so out never shows X.
  always_comb begin
    out_d = '0;
    if (!busy) begin
`ifdef RAM_PARAM_WRITE_THROUGH_EN
      // Single port: a write always targets the read address.
      out_d = bus.load ? bus.in : mem_q[bus.addr];
`else
      // Array read happens before the same-edge write lands.
      out_d = mem_q[bus.addr];
`endif
    end
  end

  // Registered read data, one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy;

endmodule : ram_param
`default_nettype wire

// File: tb/tb_ram_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_param
//  Description : Self-checking bench for ram_param (16x8 and 8x64 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_param;

`ifdef RAM_PARAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic clk;
  logic rst16_n;
  logic rst8_n;

  int errs;
  int checks;

  logic [15:0] m16 [8];
  logic [15:0] exp_q [$];

  typedef struct {
    bit        ld;
    bit [2:0]  a;
    bit [15:0] d;
    bit [15:0] exp;
  } vec_t;

  vec_t tbl [16];

  ram_param_if #(.WIDTH(16), .DEPTH(8))  b16 ();
  ram_param_if #(.WIDTH(8),  .DEPTH(64)) b8 ();

  ram_param #(.WIDTH(16), .DEPTH(8)) u_dut16 (
    .clk   (clk),
    .rst_n (rst16_n),
    .bus   (b16)
  );

  ram_param #(.WIDTH(8), .DEPTH(64)) u_dut8 (
    .clk   (clk),
    .rst_n (rst8_n),
    .bus   (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Pop the oldest expected word and compare it with the DUT output.
  task automatic pop_chk(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL %s: scoreboard empty, got %h, expected a queued value", name, act);
    end else begin
      e = {16'h0, exp_q.pop_front()};
      chk(name, act, e);
    end
  endtask

  // One 16x8 access with an explicit expected read result.
  task automatic drive16(input bit ld, input bit [2:0] a, input bit [15:0] d,
                         input bit [15:0] e, input string name);
    @(negedge clk);
    b16.load = ld;
    b16.addr = a;
    b16.in   = d;
    exp_q.push_back(e);
    if (ld) m16[a] = d;
    @(posedge clk);
    #1;
    pop_chk(name, {16'h0, b16.out});
  endtask

  // One 16x8 access with the expected result taken from the model.
  task automatic acc16(input bit ld, input bit [2:0] a, input bit [15:0] d, input string name);
    bit [15:0] e;
    e = (WT && ld) ? d : m16[a];
    drive16(ld, a, d, e, name);
  endtask

  // One 8x64 access with an explicit expected read result.
  task automatic drive8(input bit ld, input bit [5:0] a, input bit [7:0] d,
                        input bit [7:0] e, input string name);
    @(negedge clk);
    b8.load = ld;
    b8.addr = a;
    b8.in   = d;
    exp_q.push_back({8'h0, e});
    @(posedge clk);
    #1;
    pop_chk(name, {24'h0, b8.out});
  endtask

  // Count sweep edges after reset release: busy high for n edges exactly.
  task automatic sweep16(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk(name, {31'h0, b16.busy}, (i < n - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic clear_model;
    for (int i = 0; i < 8; i++) m16[i] = 16'h0;
  endtask

  initial begin
    bit [15:0] pats [8];
    errs   = 0;
    checks = 0;
    pats = '{16'h0000, 16'hFFFF, 16'h00FF, 16'hFF00,
             16'h0F0F, 16'hF0F0, 16'h3333, 16'hCCCC};
    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{ld: 1'b1, a: 3'(i), d: pats[i], exp: WT ? pats[i] : 16'h0};
      tbl[i + 8] = '{ld: 1'b0, a: 3'(i), d: 16'h0,   exp: pats[i]};
    end

    rst16_n  = 1'b0;
    rst8_n   = 1'b0;
    b16.load = 1'b0; b16.addr = '0; b16.in = '0;
    b8.load  = 1'b0; b8.addr  = '0; b8.in  = '0;
    clear_model();

    // Reset held for three cycles: out 0, busy 1.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out", {16'h0, b16.out}, 32'h0);
      chk("rst_busy", {31'h0, b16.busy}, 32'd1);
    end

    // Release reset with an access attempt that the sweep must ignore.
    @(negedge clk);
    rst16_n  = 1'b1;
    b16.load = 1'b1;
    b16.addr = 3'd3;
    b16.in   = 16'hBEEF;
    sweep16(8, "sweep_busy");

    // Every word reads zero, including the one written during the sweep.
    for (int i = 0; i < 8; i++) acc16(1'b0, 3'(i), 16'h0, "clear_read");

    // Write all, then read all.
    for (int i = 0; i < 16; i++) begin
      drive16(tbl[i].ld, tbl[i].a, tbl[i].d, tbl[i].exp, tbl[i].ld ? "tbl_write" : "tbl_read");
    end

    // Same-cycle write/read of address 5.
    acc16(1'b1, 3'd5, 16'h1234, "wr5_setup");
    drive16(1'b1, 3'd5, 16'hABCD, WT ? 16'hABCD : 16'h1234, "same_cycle");
    drive16(1'b0, 3'd5, 16'h0, 16'hABCD, "same_cycle_next");

    // Reset from READY: busy rises immediately.
    @(negedge clk);
    b16.load = 1'b0;
    rst16_n  = 1'b0;
    #1;
    chk("rst_ready_busy", {31'h0, b16.busy}, 32'd1);
    chk("rst_ready_out", {16'h0, b16.out}, 32'h0);
    @(negedge clk);
    rst16_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("part_sweep_busy", {31'h0, b16.busy}, 32'd1);
    end
    // Reset again mid-sweep; full sweep must repeat.
    @(negedge clk);
    rst16_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, b16.busy}, 32'd1);
    @(negedge clk);
    rst16_n = 1'b1;
    clear_model();
    sweep16(8, "resweep_busy");
    for (int i = 0; i < 8; i++) acc16(1'b0, 3'(i), 16'h0, "resweep_read");

    // Wide/deep scaling: 8x64 sweep lasts 64 edges.
    @(negedge clk);
    rst8_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (i == 62 || i == 63) chk("sweep64_busy", {31'h0, b8.busy}, (i < 63) ? 32'd1 : 32'd0);
    end
    drive8(1'b1, 6'd63, 8'hA5, WT ? 8'hA5 : 8'h00, "w63");
    drive8(1'b1, 6'd0,  8'h5A, WT ? 8'h5A : 8'h00, "w0");
    drive8(1'b0, 6'd63, 8'h00, 8'hA5, "r63");
    drive8(1'b0, 6'd0,  8'h00, 8'h5A, "r0");
    drive8(1'b0, 6'd31, 8'h00, 8'h00, "r31");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_ram_param
`default_nettype wire
